// File: rtl/button_debounce_pkg.sv
// button_pkg: shared definitions for the push-button conditioning block.
//   btn_state_t         debounce FSM states
//   DEBOUNCE_CYCLES_DEF default qualification length (10 ms at 100 MHz)
//   LONG_CYCLES_DEF     default long-press threshold (1 s at 100 MHz)
//   CNT_W               default width of the debounce and hold counters
package button_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned LONG_CYCLES_DEF     = 100_000_000;
  localparam int unsigned CNT_W               = 32;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_t;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous pad input.
//   clk   destination clock
//   rst_n asynchronous active-low reset, clears both flops
//   d     asynchronous input
//   q     synchronized output, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// button_debounce: turns one bouncing push-button pad into clean control signals.
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   btn_in        raw pad input, asynchronous to clk
//   btn_level     debounced state, 1 = pressed
//   press_pulse   one-cycle strobe on accepted press
//   release_pulse one-cycle strobe on accepted release
//   long_pulse    one-cycle strobe when a press has lasted LONG_CYCLES
//   btn_long      high from long_pulse until the accepted release
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W           = button_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic btn_long
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             btn_sync;
  btn_state_t       state;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt;

  logic holding;
  logic deb_done;
  logic rel_accept;
  logic long_hit;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_comb begin
    holding    = (state == PRESSED) || (state == REL_CHK);
    deb_done   = (deb_cnt == DEB_LAST);
    rel_accept = (state == REL_CHK) && !btn_sync && deb_done;
    // A release accepted on the same edge suppresses the long-press event.
    long_hit   = holding && (hold_cnt == LONG_LAST) && !btn_long && !rel_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      btn_long      <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= long_hit;
      if (long_hit) begin
        btn_long <= 1'b1;
      end

      // Press duration keeps running through REL_CHK so a bounce on
      // release does not restart the long-press timer.
      if (holding && (hold_cnt != LONG_LAST)) begin
        hold_cnt <= hold_cnt + CNT_ONE;
      end

      case (state)
        RELEASED: begin
          deb_cnt <= '0;
          if (btn_sync) begin
            state <= PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (!btn_sync) begin
            state <= RELEASED;
          end else if (deb_done) begin
            state       <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            deb_cnt <= deb_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          deb_cnt <= '0;
          if (!btn_sync) begin
            state <= REL_CHK;
          end
        end
        REL_CHK: begin
          if (btn_sync) begin
            state <= PRESSED;
          end else if (deb_done) begin
            state         <= RELEASED;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            btn_long      <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + CNT_ONE;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Stimulus pushes expected strobes (kind, cycle, level, long) into a queue;
// a monitor pops and compares whenever a strobe appears on the outputs.
module tb_button_debounce;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam int LAT  = DEB + 3;  // negedge drive -> strobe visible, in cyc units

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  typedef struct {
    int   kind;
    int   at;
    logic lvl;
    logic lng;
  } ev_t;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic btn_long;

  int   cyc;
  int   n_checks;
  int   n_fail;
  ev_t  exp_q[$];

  button_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .btn_long      (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int at, input logic lvl, input logic lng);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.lvl  = lvl;
    e.lng  = lng;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_strobe: kind %0d at cycle %0d, required none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind",  kind,      e.kind);
      chk("ev_cycle", cyc,       e.at);
      chk("ev_level", btn_level, e.lvl);
      chk("ev_long",  btn_long,  e.lng);
    end
  endtask

  // Monitor: sample 1 time unit after every active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (press_pulse && release_pulse) begin
        chk("press_and_release", 1, 0);
      end
      if (press_pulse)   check_ev(EV_PRESS);
      if (release_pulse) check_ev(EV_RELEASE);
      if (long_pulse)    check_ev(EV_LONG);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   btn_level,     0);
    chk({tag, "_press"},   press_pulse,   0);
    chk({tag, "_release"}, release_pulse, 0);
    chk({tag, "_longp"},   long_pulse,    0);
    chk({tag, "_long"},    btn_long,      0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required stimulus completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    btn_in   = 1'b1;

    // Reset held with button pressed: everything stays low.
    tick(5);
    chk_all_zero("reset");
    rst_n = 1'b1;
    t = cyc;
    expect_ev(EV_PRESS, t + LAT, 1'b1, 1'b0);
    tick(12);
    chk("reset_press_level", btn_level, 1);
    btn_in = 1'b0;
    t = cyc;
    expect_ev(EV_RELEASE, t + LAT, 1'b0, 1'b0);
    tick(12);

    // Clean press / release.
    btn_in = 1'b1;
    t = cyc;
    expect_ev(EV_PRESS, t + LAT, 1'b1, 1'b0);
    tick(8);
    chk("clean_level_high", btn_level, 1);
    btn_in = 1'b0;
    t = cyc;
    expect_ev(EV_RELEASE, t + LAT, 1'b0, 1'b0);
    tick(10);
    chk("clean_level_low", btn_level, 0);

    // Bounces of 1, 2 and 3 cycles are rejected.
    for (int w = 1; w <= 3; w++) begin
      btn_in = 1'b1;
      tick(w);
      btn_in = 1'b0;
      tick(3);
      chk("bounce_level", btn_level, 0);
    end
    btn_in = 1'b1;
    t = cyc;
    expect_ev(EV_PRESS, t + LAT, 1'b1, 1'b0);
    tick(10);
    btn_in = 1'b0;
    t = cyc;
    expect_ev(EV_RELEASE, t + LAT, 1'b0, 1'b0);
    tick(12);

    // Long press held for 40 cycles.
    btn_in = 1'b1;
    t = cyc;
    expect_ev(EV_PRESS, t + LAT, 1'b1, 1'b0);
    expect_ev(EV_LONG, t + LAT + LONG, 1'b1, 1'b1);
    tick(26);
    chk("long_not_yet", btn_long, 0);
    tick(4);
    chk("long_held", btn_long, 1);
    tick(10);
    btn_in = 1'b0;
    t = cyc;
    expect_ev(EV_RELEASE, t + LAT, 1'b0, 1'b0);
    tick(5);
    chk("long_before_release", btn_long, 1);
    tick(10);
    chk("long_cleared", btn_long, 0);

    // Release acceptance lands on the long-press edge: release wins.
    btn_in = 1'b1;
    t = cyc;
    expect_ev(EV_PRESS, t + LAT, 1'b1, 1'b0);
    tick(LONG);
    btn_in = 1'b0;
    expect_ev(EV_RELEASE, t + LAT + LONG, 1'b0, 1'b0);
    tick(12);
    chk("collision_long", btn_long, 0);

    // Reset during PRESS_CHK.
    btn_in = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_presschk");
    btn_in = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(15);

    // Reset during REL_CHK with btn_long set.
    btn_in = 1'b1;
    t = cyc;
    expect_ev(EV_PRESS, t + LAT, 1'b1, 1'b0);
    expect_ev(EV_LONG, t + LAT + LONG, 1'b1, 1'b1);
    tick(30);
    chk("relchk_long_set", btn_long, 1);
    btn_in = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_relchk");
    tick(3);
    rst_n = 1'b1;
    tick(20);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Conditions one raw mechanical push-button or slide-switch input into clean, single-clock-domain control signals for the board: a debounced level, one-cycle press and release strobes, and a long-press indication. It is the input-side counterpart to the free-running LED output blinkers. It feeds mode-select and reset-request logic in the video card top level.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz); must be ≥ 1.
- LONG_CYCLES, 100_000_000: cycles after press_pulse at which a held press becomes "long" (1 s at 100 MHz); must be ≥ 1.
- CNT_W, 32: width of both internal counters; must hold DEBOUNCE_CYCLES-1 and LONG_CYCLES-1.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  1  raw pad input, asynchronous to clk, bounces.
- btn_level  out  1  debounced button state, 1 = pressed.
- press_pulse  out  1  one-cycle strobe on accepted press.
- release_pulse  out  1  one-cycle strobe on accepted release.
- long_pulse  out  1  one-cycle strobe when a press reaches LONG_CYCLES.
- btn_long  out  1  high from long_pulse until the accepted release.

## Operation
- btn_in passes through a 2-flop synchronizer; the FSM uses only btn_sync.
- Two counters: deb_cnt for debounce qualification and hold_cnt for press duration. Both are CNT_W wide.
- The FSM has four states: RELEASED, PRESS_CHK, PRESSED and REL_CHK.
- **RELEASED** (btn_level=0)
  - btn_sync=1 → PRESS_CHK, deb_cnt←0.
- **PRESS_CHK** (btn_level=0)
  - btn_sync=0 → RELEASED. The bounce is rejected and no strobe is issued.
  - btn_sync=1 and deb_cnt=DEBOUNCE_CYCLES-1 → PRESSED. On this edge: btn_level←1, press_pulse←1, hold_cnt←0.
  - Otherwise deb_cnt increments.
- **PRESSED** (btn_level=1)
  - btn_sync=0 → REL_CHK, deb_cnt←0.
  - hold_cnt increments, saturating at LONG_CYCLES-1.
- **REL_CHK** (btn_level=1)
  - btn_sync=1 → PRESSED. hold_cnt is not cleared, so the press duration continues.
  - btn_sync=0 and deb_cnt=DEBOUNCE_CYCLES-1 → RELEASED. On this edge: btn_level←0, release_pulse←1, btn_long←0.
  - Otherwise deb_cnt increments.
  - hold_cnt keeps incrementing and saturating as in PRESSED.
- **Long press**
  - Fires in PRESSED or REL_CHK when hold_cnt=LONG_CYCLES-1 and btn_long=0.
  - On that edge: long_pulse←1, btn_long←1.
  - It fires at most once per press.
- **Simultaneous events**
  - If the release acceptance and the long condition fall on the same edge, the release wins: long_pulse is not asserted and btn_long stays 0.
- **Reset**
  - rst_n low at any time, including mid-debounce or mid-hold, forces state RELEASED, zeroes the synchronizer flops and both counters, and drives every output to 0.
  - No strobe is emitted on reset entry or exit.
- All outputs are registered.

## Timing
- Reset values: btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0, btn_long=0.
- Edge 0 is the first clk edge that samples btn_in=1 (held stable).
  - btn_sync=1 after edge 1.
  - PRESS_CHK is entered at edge 2.
  - press_pulse and btn_level rise at edge DEBOUNCE_CYCLES+2.
- Release latency from the first sampled low is symmetric: DEBOUNCE_CYCLES+2 edges.
- long_pulse rises exactly LONG_CYCLES edges after the press_pulse edge, provided the press is not released.
- Any btn_sync glitch shorter than DEBOUNCE_CYCLES cycles causes no output change.
- All pulses are exactly one cycle wide. press_pulse and release_pulse are never both high in the same cycle.

## Structure
- Package button_pkg holds:
  - the state enum (RELEASED, PRESS_CHK, PRESSED, REL_CHK);
  - default constants DEBOUNCE_CYCLES_DEF and LONG_CYCLES_DEF;
  - CNT_W.
- Sub-module sync_2ff (clk, rst_n, d, q) is the synchronizer. It is reused by other pad inputs.
- The top module holds the FSM, both counters and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
- **Reset:** hold rst_n=0 with btn_in=1 → all outputs 0; release rst_n → press_pulse at exactly 6 edges after the first sample.
- **Clean press:** btn_in 0→1 held → press_pulse high for one cycle at edge 6 with btn_level=1; drop btn_in → release_pulse high at edge 6 after the low, btn_level=0.
- **Bounce reject:** toggle btn_in with high widths of 1, 2 and 3 cycles separated by lows → no pulses, btn_level stays 0; then hold 10 cycles → exactly one press_pulse.
- **Long press:** hold for 40 cycles → long_pulse 20 edges after press_pulse, btn_long=1 until release_pulse, and only one long_pulse.
- **Release/long collision:** time the release acceptance onto the long edge → release_pulse=1, long_pulse=0, btn_long=0.
- **Mid-operation reset:** assert rst_n=0 during PRESS_CHK and again during REL_CHK with btn_long=1 → outputs clear asynchronously; no pulses after rst_n deasserts with btn_in=0.
